multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 156 +++++++++++++++
 tb/tb_multicycle_control.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-unit bus between instruction/memory side and datapath enables
// master = datapath/instruction side, slave = multicycle_control.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;

  modport master (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM
// Jump support enabled by defining MULTICYCLE_CONTROL_JUMP_EN.
module multicycle_control (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.slave   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    illegal       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // rst gating keeps PC/IR from loading while reset holds the FSM here
        if (bus.mem_ready && !rst) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        state_d = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_ADDI:       state_d = ADDIEX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:          state_d = JUMP;
`endif
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.opcode == OP_LW)      state_d = MEMRD;
        else if (bus.opcode == OP_SW) state_d = MEMWR;
        else                          state_d = FETCH;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_src        = pc_src;
  assign bus.state         = state_q;
  assign bus.illegal       = illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control
// Jump expectations follow MULTICYCLE_CONTROL_JUMP_EN.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    #2;
    chk("rst_state",     bus.state,     4'd0);
    chk("rst_mem_read",  bus.mem_read,  4'd1);
    chk("rst_alu_src_b", bus.alu_src_b, 4'd1);
    chk("rst_pc_write",  bus.pc_write,  4'd0);
    chk("rst_ir_write",  bus.ir_write,  4'd0);
    step();
    chk("rst_hold_state", bus.state, 4'd0);
    rst = 1'b0;
    #1;

    // R-type: 0,1,6,7,0
    chk("r_fetch_ir_write", bus.ir_write, 4'd1);
    chk("r_fetch_pc_write", bus.pc_write, 4'd1);
    step(); chk("r_s1", bus.state, 4'd1);
    chk("r_dec_alu_src_b", bus.alu_src_b, 4'd3);
    chk("r_dec_illegal", bus.illegal, 4'd0);
    step(); chk("r_s6", bus.state, 4'd6);
    chk("r_exec_alu_op", bus.alu_op, 4'd2);
    chk("r_exec_reg_write", bus.reg_write, 4'd0);
    step(); chk("r_s7", bus.state, 4'd7);
    chk("r_wb_reg_write", bus.reg_write, 4'd1);
    chk("r_wb_reg_dst", bus.reg_dst, 4'd1);
    step(); chk("r_s0", bus.state, 4'd0);

    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
    bus.opcode = 6'b100011;
    step(); chk("lw_s1", bus.state, 4'd1);
    step(); chk("lw_s2", bus.state, 4'd2);
    chk("lw_adr_alu_src_b", bus.alu_src_b, 4'd2);
    step(); chk("lw_s3a", bus.state, 4'd3);
    bus.mem_ready = 1'b0;
    #1;
    chk("lw_rd_i_or_d", bus.i_or_d, 4'd1);
    step(); chk("lw_s3b", bus.state, 4'd3);
    step(); chk("lw_s3c", bus.state, 4'd3);
    bus.mem_ready = 1'b1;
    step(); chk("lw_s4", bus.state, 4'd4);
    chk("lw_wb_mem_to_reg", bus.mem_to_reg, 4'd1);
    chk("lw_wb_reg_dst", bus.reg_dst, 4'd0);
    step(); chk("lw_s0", bus.state, 4'd0);

    // sw with three wait cycles in FETCH
    bus.opcode    = 6'b101011;
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_ir_write", bus.ir_write, 4'd0);
      chk("sw_wait_state", bus.state, 4'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_ir_write", bus.ir_write, 4'd1);
    step(); chk("sw_s1", bus.state, 4'd1);
    step(); chk("sw_s2", bus.state, 4'd2);
    step(); chk("sw_s5", bus.state, 4'd5);
    chk("sw_mem_write", bus.mem_write, 4'd1);
    step(); chk("sw_s0", bus.state, 4'd0);

    // beq: 0,1,8,0
    bus.opcode = 6'b000100;
    step(); chk("beq_s1", bus.state, 4'd1);
    step(); chk("beq_s8", bus.state, 4'd8);
    chk("beq_pc_write_cond", bus.pc_write_cond, 4'd1);
    chk("beq_alu_op", bus.alu_op, 4'd1);
    chk("beq_pc_src", bus.pc_src, 4'd1);
    step(); chk("beq_s0", bus.state, 4'd0);

    // addi: 0,1,9,10,0
    bus.opcode = 6'b001000;
    step(); chk("addi_s1", bus.state, 4'd1);
    step(); chk("addi_s9", bus.state, 4'd9);
    chk("addi_ex_alu_src_b", bus.alu_src_b, 4'd2);
    step(); chk("addi_s10", bus.state, 4'd10);
    chk("addi_wb_reg_write", bus.reg_write, 4'd1);
    chk("addi_wb_reg_dst", bus.reg_dst, 4'd0);
    step(); chk("addi_s0", bus.state, 4'd0);

    // jump opcode
    bus.opcode = 6'b000010;
    step(); chk("j_s1", bus.state, 4'd1);
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    chk("j_illegal", bus.illegal, 4'd0);
    step(); chk("j_s11", bus.state, 4'd11);
    chk("j_pc_write", bus.pc_write, 4'd1);
    chk("j_pc_src", bus.pc_src, 4'd2);
`else
    chk("j_illegal", bus.illegal, 4'd1);
`endif
    step(); chk("j_s0", bus.state, 4'd0);
    chk("j_illegal_clear", bus.illegal, 4'd0);

    // unsupported opcode
    bus.opcode = 6'b111111;
    step(); chk("ill_s1", bus.state, 4'd1);
    chk("ill_illegal", bus.illegal, 4'd1);
    step(); chk("ill_s0", bus.state, 4'd0);
    chk("ill_illegal_clear", bus.illegal, 4'd0);

    // asynchronous reset during a MEMRD wait
    bus.opcode = 6'b100011;
    step(); step(); step();
    chk("arst_pre_s3", bus.state, 4'd3);
    bus.mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", bus.state, 4'd0);
    chk("arst_mem_read", bus.mem_read, 4'd1);
    chk("arst_mem_write", bus.mem_write, 4'd0);
    chk("arst_reg_write", bus.reg_write, 4'd0);
    bus.mem_ready = 1'b1;
    #1;
    chk("arst_pc_write_gated", bus.pc_write, 4'd0);
    chk("arst_ir_write_gated", bus.ir_write, 4'd0);
    step();
    chk("arst_hold_state", bus.state, 4'd0);
    rst = 1'b0;
    #1;
    chk("arst_release_ir_write", bus.ir_write, 4'd1);
    step(); chk("arst_first_fetch_s1", bus.state, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
